cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Controller for the direct-mapped, write-back, write-allocate data cache built from four `block` lines of 4 words and 26-bit tags each. It sits between the pipeline MEM stage and the word-wide main-memory port. On a hit it completes CPU accesses in the same cycle. On a miss it stalls the CPU, writes back a dirty victim line word by word, then refills the line word by word.

## Interface
Parameters:
- none. Geometry is fixed: tag [31:6], index [5:4], word offset [3:2], byte [1:0] ignored.

Ports:
- CLK  in  1  clock. All state changes on the rising edge.
- ResetN  in  1  asynchronous, active-low reset. Cache lines are reset by the top level with `!ResetN`.
- CpuReq  in  1  CPU access request. Held with CpuAddr/CpuWE/CpuWD stable until CpuReady.
- CpuWE  in  1  1 = store, 0 = load.
- CpuAddr  in  32  byte address.
- CpuWD  in  32  store data.
- CpuRD  out  32  load data. Valid when CpuReady=1 and CpuWE=0.
- CpuReady  out  1  access completes this cycle. Pipeline stall = CpuReq & !CpuReady.
- LineSel  out  2  selects the cache line. Drives the line-enable decode and the read mux.
- Offset  out  2  word offset to the selected line.
- BlkWE, SetValid, SetDirty  out  1 each  write controls to the selected line.
- SetTag  out  26  tag written to the selected line.
- BlkWD  out  32  data written to the selected line.
- Valid, Dirty  in  1 each  status of the selected line.
- Tag  in  26  tag of the selected line.
- RD  in  32  word `Offset` of the selected line.
- MemReq  out  1  memory word transfer request.
- MemWE  out  1  1 = write to memory.
- MemAddr  out  32  word-aligned address, [1:0]=00.
- MemWD  out  32  write data to memory.
- MemRD  in  32  read data from memory. Valid when MemReady=1.
- MemReady  in  1  the current word transfer completes this cycle.
- MissCount  out  16  number of misses since reset. Wraps at 16'hFFFF to 0.

## Operation
- Registers: state ∈ {IDLE, WB, REFILL}, cnt[1:0], reqAddr[31:0], MissCount.
- Line address source:
  - In IDLE, LineSel and Offset come from CpuAddr.
  - In WB and REFILL, LineSel = reqAddr[5:4] and Offset = cnt.
- hit = Valid & (Tag == CpuAddr[31:6]), evaluated in IDLE only.
- IDLE:
  - CpuReq & hit & !CpuWE: CpuRD=RD, CpuReady=1.
  - CpuReq & hit & CpuWE:
    - BlkWE=1, BlkWD=CpuWD.
    - SetValid=1, SetDirty=1, SetTag=CpuAddr[31:6].
    - CpuReady=1.
  - CpuReq & !hit:
    - CpuReady=0; reqAddr<=CpuAddr; cnt<=0; MissCount++.
    - Next state is WB if Dirty (Dirty already includes Valid), else REFILL.
  - !CpuReq: all write and request outputs are 0.
- WB:
  - MemReq=1, MemWE=1, MemAddr={Tag, reqAddr[5:4], cnt, 2'b00}, MemWD=RD, BlkWE=0.
  - On MemReady: cnt++. If cnt==3, go to REFILL with cnt<=0.
- REFILL:
  - MemReq=1, MemWE=0, MemAddr={reqAddr[31:4], cnt, 2'b00}.
  - On MemReady:
    - BlkWE=1, BlkWD=MemRD.
    - SetTag=reqAddr[31:6], SetDirty=0.
    - SetValid = (cnt==3). The line is invalid during refill, so no partial-line hit is possible.
    - cnt++. If cnt==3, go to IDLE.
- After refill, IDLE re-evaluates the still-held request. It now hits, and a store hit sets dirty.
- CpuReady=0 in WB and REFILL.
- MemReq=0 in IDLE.
- Outputs not listed for a state are 0; CpuRD=RD always.

## Timing
- Reset (ResetN=0, asynchronous):
  - state=IDLE, cnt=0, reqAddr=0, MissCount=0.
  - MemReq=0, BlkWE=0, CpuReady=0.
  - Lines invalid.
- Hit latency is 0 cycles: CpuReady is combinational in the CpuReq cycle. A store hit writes on that edge.
- Clean miss with MemReady stuck at 1: 1 detect cycle + 4 REFILL cycles + 1 hit cycle = CpuReady in the 6th cycle.
- Dirty miss: 10 cycles (4 extra WB cycles).
- MemReady=0 holds MemReq, MemAddr, MemWD and cnt stable. No partial word is ever committed.
- Reset mid-WB or mid-REFILL aborts immediately:
  - MemReq drops asynchronously.
  - The partially refilled line stays invalid.
- A CpuReq deasserted during a miss is a protocol violation. The controller still finishes the line fill.

## Test plan
- Cold load 0x0000_0010, memory returns words A0..A3, MemReady=1:
  - REFILL MemAddr sequence 0x10, 0x14, 0x18, 0x1C.
  - CpuReady in cycle 6 with CpuRD=A0.
  - MissCount=1.
- Load hit 0x0000_0018 after fill -> CpuReady same cycle, CpuRD=A2, MemReq stays 0.
- Store hit 0x0000_0014 with 0xDEADBEEF -> line Dirty=1. A following load of 0x14 returns 0xDEADBEEF in 0 cycles.
- Conflict load 0x0000_0410 (same index, tag differs) on the dirty line:
  - WB writes 0x10..0x1C with A0, 0xDEADBEEF, A2, A3.
  - Then refills 0x410..0x41C.
  - CpuReady in cycle 10.
  - MissCount=2.
- MemReady toggled 1,0,0,1,… during refill -> each word is written only on a MemReady=1 cycle, and MemAddr is stable across wait cycles.
- ResetN pulled low after the 2nd refill word -> MemReq=0 immediately, state=IDLE, MissCount=0. The next access to the same address misses again.

Source files
------------

// File: rtl/cache_ctrl_if.sv
// rtl/cache_ctrl_if.sv - CPU, cache-line and memory signal bundle for cache_ctrl
//
// Purpose: carries every handshake/bus signal between the cache controller
// and its neighbours. The controller connects through the master modport.
// The environment connects through the slave modport. The environment is
// the MEM stage, the four cache lines and the main-memory port.
//
// Signal summary:
//   CPU side   : CpuReq, CpuWE, CpuAddr, CpuWD -> ctrl; CpuRD, CpuReady <- ctrl
//   Line side  : LineSel, Offset, BlkWE, SetValid, SetDirty, SetTag, BlkWD <- ctrl
//                Valid, Dirty, Tag, RD -> ctrl (status/data of the selected line)
//   Memory side: MemReq, MemWE, MemAddr, MemWD <- ctrl; MemRD, MemReady -> ctrl
interface cache_ctrl_if;
    // CPU / MEM stage
    logic        CpuReq;
    logic        CpuWE;
    logic [31:0] CpuAddr;
    logic [31:0] CpuWD;
    logic [31:0] CpuRD;
    logic        CpuReady;

    // Cache line array
    logic [1:0]  LineSel;
    logic [1:0]  Offset;
    logic        BlkWE;
    logic        SetValid;
    logic        SetDirty;
    logic [25:0] SetTag;
    logic [31:0] BlkWD;
    logic        Valid;
    logic        Dirty;
    logic [25:0] Tag;
    logic [31:0] RD;

    // Main memory word port
    logic        MemReq;
    logic        MemWE;
    logic [31:0] MemAddr;
    logic [31:0] MemWD;
    logic [31:0] MemRD;
    logic        MemReady;

    modport master (
        input  CpuReq, CpuWE, CpuAddr, CpuWD,
        output CpuRD, CpuReady,
        output LineSel, Offset, BlkWE, SetValid, SetDirty, SetTag, BlkWD,
        input  Valid, Dirty, Tag, RD,
        output MemReq, MemWE, MemAddr, MemWD,
        input  MemRD, MemReady
    );

    modport slave (
        output CpuReq, CpuWE, CpuAddr, CpuWD,
        input  CpuRD, CpuReady,
        input  LineSel, Offset, BlkWE, SetValid, SetDirty, SetTag, BlkWD,
        output Valid, Dirty, Tag, RD,
        input  MemReq, MemWE, MemAddr, MemWD,
        output MemRD, MemReady
    );
endinterface

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
//
// Purpose: controls four external 4-word cache lines with 26-bit tags.
// Address split: tag [31:6], index [5:4], word [3:2]; bits [1:0] are ignored.
// A hit completes combinationally in the request cycle, and a store hit
// writes on that edge. A miss stalls the CPU. A dirty victim is first
// written back word by word (WB). The line is then refilled word by word
// (REFILL). Control then returns to IDLE, where the still-held request
// now hits.
//
// Ports:
//   CLK       - clock, rising edge
//   ResetN    - asynchronous active-low reset
//   bus       - cache_ctrl_if.master (CPU, cache-line and memory signals)
//   MissCount - 16-bit miss counter since reset, wraps
module cache_ctrl (
    input  logic          CLK,
    input  logic          ResetN,
    cache_ctrl_if.master  bus,
    output logic [15:0]   MissCount
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        REFILL = 2'd2
    } state_t;

    state_t       state, state_next;
    logic [1:0]   cnt, cnt_next;
    // Only the line address of the missing request is needed later.
    logic [31:4]  reqAddr, reqAddr_next;
    logic         miss_inc;
    logic         hit;

    // Only meaningful in IDLE, where LineSel/Offset follow CpuAddr.
    assign hit = bus.Valid && (bus.Tag == bus.CpuAddr[31:6]);

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            reqAddr   <= '0;
            MissCount <= 16'd0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            reqAddr <= reqAddr_next;
            if (miss_inc) begin
                MissCount <= MissCount + 16'd1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        reqAddr_next = reqAddr;
        miss_inc     = 1'b0;

        bus.CpuRD    = bus.RD;
        bus.CpuReady = 1'b0;
        bus.LineSel  = reqAddr[5:4];
        bus.Offset   = cnt;
        bus.BlkWE    = 1'b0;
        bus.SetValid = 1'b0;
        bus.SetDirty = 1'b0;
        bus.SetTag   = 26'd0;
        bus.BlkWD    = 32'd0;
        bus.MemReq   = 1'b0;
        bus.MemWE    = 1'b0;
        bus.MemAddr  = 32'd0;
        bus.MemWD    = 32'd0;

        unique case (state)
            IDLE: begin
                bus.LineSel = bus.CpuAddr[5:4];
                bus.Offset  = bus.CpuAddr[3:2];
                // ResetN gating keeps CpuReady and line writes quiet while
                // reset is asserted, even though the request may be held.
                if (bus.CpuReq && ResetN) begin
                    if (hit) begin
                        bus.CpuReady = 1'b1;
                        if (bus.CpuWE) begin
                            bus.BlkWE    = 1'b1;
                            bus.BlkWD    = bus.CpuWD;
                            bus.SetValid = 1'b1;
                            bus.SetDirty = 1'b1;
                            bus.SetTag   = bus.CpuAddr[31:6];
                        end
                    end else begin
                        reqAddr_next = bus.CpuAddr[31:4];
                        cnt_next     = 2'd0;
                        miss_inc     = 1'b1;
                        // Dirty is only set on a valid line, so it alone
                        // decides whether a victim must be written back.
                        state_next   = bus.Dirty ? WB : REFILL;
                    end
                end
            end

            WB: begin
                // The victim tag still sits in the line during write-back.
                bus.MemReq  = 1'b1;
                bus.MemWE   = 1'b1;
                bus.MemAddr = {bus.Tag, reqAddr[5:4], cnt, 2'b00};
                bus.MemWD   = bus.RD;
                if (bus.MemReady) begin
                    cnt_next = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        cnt_next   = 2'd0;
                        state_next = REFILL;
                    end
                end
            end

            REFILL: begin
                bus.MemReq  = 1'b1;
                bus.MemWE   = 1'b0;
                bus.MemAddr = {reqAddr[31:4], cnt, 2'b00};
                if (bus.MemReady) begin
                    bus.BlkWE    = 1'b1;
                    bus.BlkWD    = bus.MemRD;
                    bus.SetTag   = reqAddr[31:6];
                    bus.SetDirty = 1'b0;
                    // The first word clears Valid, so a half-filled line
                    // can never produce a hit. Only the last word sets it.
                    bus.SetValid = (cnt == 2'd3);
                    cnt_next     = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - scoreboard testbench for cache_ctrl
module tb_cache_ctrl;

    logic        CLK;
    logic        ResetN;
    logic [15:0] MissCount;

    cache_ctrl_if bus();

    cache_ctrl dut (
        .CLK       (CLK),
        .ResetN    (ResetN),
        .bus       (bus),
        .MissCount (MissCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- cache line array model ----------------
    logic [3:0]  lv, ld;
    logic [25:0] lt [4];
    logic [31:0] ldata [4][4];

    assign bus.Valid = lv[bus.LineSel];
    assign bus.Dirty = ld[bus.LineSel];
    assign bus.Tag   = lt[bus.LineSel];
    assign bus.RD    = ldata[bus.LineSel][bus.Offset];

    always @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            lv <= '0;
            ld <= '0;
        end else if (bus.BlkWE) begin
            ldata[bus.LineSel][bus.Offset] <= bus.BlkWD;
            lv[bus.LineSel] <= bus.SetValid;
            ld[bus.LineSel] <= bus.SetDirty;
            lt[bus.LineSel] <= bus.SetTag;
        end
    end

    // ---------------- main memory model ----------------
    logic [31:0] mem [1024];
    assign bus.MemRD = mem[bus.MemAddr[11:2]];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        for (int i = 0; i < 4; i++) begin
            mem[4 + i]     = 32'hA000_0000 + i;   // 0x10..0x1C
            mem[8 + i]     = 32'hC000_0000 + i;   // 0x20..0x2C
            mem[12 + i]    = 32'hD000_0000 + i;   // 0x30..0x3C
            mem[260 + i]   = 32'hB000_0000 + i;   // 0x410..0x41C
        end
        for (int l = 0; l < 4; l++) begin
            lt[l] = 26'd0;
            for (int w = 0; w < 4; w++) ldata[l][w] = 32'd0;
        end
    end

    // ---------------- scoreboard queues ----------------
    typedef struct {
        logic        we;
        logic [31:0] rd;
        int          lat;
    } cpu_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
    } mem_exp_t;

    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];

    task automatic exp_mem(input logic [31:0] addr, input logic we, input logic [31:0] wd);
        mem_q.push_back('{addr, we, wd});
    endtask

    // ---------------- monitor ----------------
    int cyc = 0;

    always @(negedge CLK) begin
        if (!ResetN) begin
            cyc = 0;
        end else begin
            if (bus.MemReq) begin
                if (mem_q.size() == 0) begin
                    chk("mem_unexpected_req", {31'd0, bus.MemReq}, 32'd0);
                end else begin
                    // Checked on wait cycles too: address/data must hold.
                    chk("mem_addr", bus.MemAddr, mem_q[0].addr);
                    chk("mem_we", {31'd0, bus.MemWE}, {31'd0, mem_q[0].we});
                    if (mem_q[0].we) chk("mem_wd", bus.MemWD, mem_q[0].wd);
                    if (bus.MemReady) void'(mem_q.pop_front());
                end
                if (!bus.MemReady && bus.BlkWE)
                    chk("blkwe_without_memready", {31'd0, bus.BlkWE}, 32'd0);
            end
            if (bus.CpuReq) begin
                cyc = cyc + 1;
                if (bus.CpuReady) begin
                    if (cpu_q.size() == 0) begin
                        chk("cpu_unexpected_ready", {31'd0, bus.CpuReady}, 32'd0);
                    end else begin
                        chk("cpu_latency", cyc, cpu_q[0].lat);
                        if (!cpu_q[0].we) chk("cpu_rd", bus.CpuRD, cpu_q[0].rd);
                        void'(cpu_q.pop_front());
                    end
                    cyc = 0;
                end
            end else begin
                cyc = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at posedge+#1; returns at posedge+#1 after the completing edge.
    task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] exp_rd, input int lat, input bit toggle);
        bit done;
        cpu_q.push_back('{we, exp_rd, lat});
        bus.CpuWE   = we;
        bus.CpuAddr = addr;
        bus.CpuWD   = wd;
        bus.CpuReq  = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            bus.MemReady = toggle ? (i % 3 == 0) : 1'b1;
            @(negedge CLK);
            if (bus.CpuReady) done = 1'b1;
            else begin
                @(posedge CLK);
                #1;
            end
        end
        if (!done) chk("cpu_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1;
        bus.MemReady = 1'b1;
    endtask

    initial begin
        ResetN       = 1'b0;
        bus.CpuReq   = 1'b1;
        bus.CpuWE    = 1'b0;
        bus.CpuAddr  = 32'h0000_0010;
        bus.CpuWD    = 32'd0;
        bus.MemReady = 1'b1;

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_memreq", {31'd0, bus.MemReq}, 32'd0);
        chk("rst_blkwe", {31'd0, bus.BlkWE}, 32'd0);
        chk("rst_cpuready", {31'd0, bus.CpuReady}, 32'd0);
        chk("rst_misscount", {16'd0, MissCount}, 32'd0);
        bus.CpuReq = 1'b0;
        ResetN = 1'b1;
        @(posedge CLK);
        #1;

        // Cold load 0x10
        for (int i = 0; i < 4; i++) exp_mem(32'h10 + 4 * i, 1'b0, 32'd0);
        cpu_access(1'b0, 32'h10, 32'd0, 32'hA000_0000, 6, 1'b0);
        chk("misscount_cold", {16'd0, MissCount}, 32'd1);

        // Load hit, store hit, load-back
        cpu_access(1'b0, 32'h18, 32'd0, 32'hA000_0002, 1, 1'b0);
        cpu_access(1'b1, 32'h14, 32'hDEAD_BEEF, 32'd0, 1, 1'b0);
        chk("line1_dirty", {31'd0, ld[1]}, 32'd1);
        cpu_access(1'b0, 32'h14, 32'd0, 32'hDEAD_BEEF, 1, 1'b0);
        chk("misscount_hits", {16'd0, MissCount}, 32'd1);

        // Conflict load on dirty line: write-back then refill
        exp_mem(32'h10, 1'b1, 32'hA000_0000);
        exp_mem(32'h14, 1'b1, 32'hDEAD_BEEF);
        exp_mem(32'h18, 1'b1, 32'hA000_0002);
        exp_mem(32'h1C, 1'b1, 32'hA000_0003);
        for (int i = 0; i < 4; i++) exp_mem(32'h410 + 4 * i, 1'b0, 32'd0);
        cpu_access(1'b0, 32'h410, 32'd0, 32'hB000_0000, 10, 1'b0);
        chk("misscount_conflict", {16'd0, MissCount}, 32'd2);
        chk("line1_clean", {31'd0, ld[1]}, 32'd0);

        // Refill with MemReady 1,0,0,1,...: words land on cycles 4,7,10,13
        for (int i = 0; i < 4; i++) exp_mem(32'h20 + 4 * i, 1'b0, 32'd0);
        cpu_access(1'b0, 32'h28, 32'd0, 32'hC000_0002, 14, 1'b1);
        chk("misscount_toggle", {16'd0, MissCount}, 32'd3);

        // Reset after the second refill word
        exp_mem(32'h30, 1'b0, 32'd0);
        exp_mem(32'h34, 1'b0, 32'd0);
        bus.CpuWE   = 1'b0;
        bus.CpuAddr = 32'h30;
        bus.CpuReq  = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("pre_rst_memreq", {31'd0, bus.MemReq}, 32'd1);
        chk("pre_rst_memaddr", bus.MemAddr, 32'h38);
        ResetN = 1'b0;
        #1;
        chk("midrst_memreq", {31'd0, bus.MemReq}, 32'd0);
        chk("midrst_cpuready", {31'd0, bus.CpuReady}, 32'd0);
        chk("midrst_misscount", {16'd0, MissCount}, 32'd0);
        chk("midrst_line3_valid", {31'd0, lv[3]}, 32'd0);
        bus.CpuReq = 1'b0;
        @(negedge CLK);
        ResetN = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_rst_memreq", {31'd0, bus.MemReq}, 32'd0);

        // Same address misses again
        for (int i = 0; i < 4; i++) exp_mem(32'h30 + 4 * i, 1'b0, 32'd0);
        cpu_access(1'b0, 32'h30, 32'd0, 32'hD000_0000, 6, 1'b0);
        chk("misscount_after_rst", {16'd0, MissCount}, 32'd1);
        bus.CpuReq = 1'b0;

        repeat (2) @(posedge CLK);
        chk("mem_q_drained", mem_q.size(), 32'd0);
        chk("cpu_q_drained", cpu_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
